// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// load/store, and builds the pipeline stall vector. Optional counters: MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              id_stall_req,
  output logic [5:0]        stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_mem_wait,
  output logic [15:0]       perf_drop
`endif
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  state_t   state_q, state_d;
  bus_cmd_t cmd_q, cmd_d;
  logic     drop_q;
  logic     grant_mem, grant_if;
  logic     if_end, mem_end, if_kill, drop_set;

  assign bus_we    = cmd_q.we;
  assign bus_sel   = cmd_q.sel;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;

  // A requester whose done pulse is showing is already served; masking it
  // keeps the stale request from being granted a second time.
  assign stall = ((mem_req & ~mem_done) ? 6'b011111 : 6'b000000)
               | (id_stall_req          ? 6'b000111 : 6'b000000)
               | ((if_req & ~if_done)   ? 6'b000011 : 6'b000000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_mem)     state_d = MEM_BUSY;
        else if (grant_if) state_d = IF_BUSY;
      end
      IF_BUSY, MEM_BUSY: if (bus_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state_q == IDLE) begin
      grant_mem = mem_req & ~mem_done;
      grant_if  = ~grant_mem & if_req & ~if_done;
    end
    if_end   = (state_q == IF_BUSY) & bus_ready;
    mem_end  = (state_q == MEM_BUSY) & bus_ready;
    // A flush landing on the completing cycle kills that fetch too.
    if_kill  = drop_q | if_flush;
    drop_set = if_flush & (grant_if | ((state_q == IF_BUSY) & ~bus_ready));
    cmd_d    = cmd_q;
    if (grant_mem) begin
      cmd_d.we    = mem_we;
      cmd_d.sel   = mem_sel;
      cmd_d.addr  = mem_addr;
      cmd_d.wdata = mem_wdata;
    end else if (grant_if) begin
      cmd_d.we    = 1'b0;
      cmd_d.sel   = 4'hF;
      cmd_d.addr  = if_addr;
      cmd_d.wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      cmd_q     <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      drop_q    <= 1'b0;
    end else begin
      bus_req  <= (state_d != IDLE);
      cmd_q    <= cmd_d;
      if_done  <= if_end & ~if_kill;
      mem_done <= mem_end;
      if (if_end && !if_kill)   if_rdata  <= bus_rdata;
      if (mem_end && !cmd_q.we) mem_rdata <= bus_rdata;
      if (if_end)        drop_q <= 1'b0;
      else if (drop_set) drop_q <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_wait  <= '0;
      perf_mem_wait <= '0;
      perf_drop     <= '0;
    end else if (perf_clr) begin
      perf_if_wait  <= '0;
      perf_mem_wait <= '0;
      perf_drop     <= '0;
    end else begin
      if (stall[1] && perf_if_wait != '1)          perf_if_wait  <= perf_if_wait + 32'd1;
      if (stall[4] && perf_mem_wait != '1)         perf_mem_wait <= perf_mem_wait + 32'd1;
      if (if_end && if_kill && perf_drop != '1)    perf_drop     <= perf_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected read data,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, if_done;
  logic [31:0] if_addr = '0, if_rdata;
  logic        mem_req = 1'b0, mem_we = 1'b0, mem_done;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic        id_stall_req = 1'b0;
  logic [5:0]  stall;
  logic        bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0, errors = 0;
  int rdy_dly = 1, busy_cnt = 0;
  int if_seen = 0, mem_seen = 0;
  logic [31:0] if_q[$], mem_q[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .id_stall_req(id_stall_req), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Bus slave: ready on the rdy_dly-th cycle of a request; data = addr ^ A5A50000.
  always @(negedge clk) begin
    if (bus_req) begin
      bus_ready = (busy_cnt + 1 >= rdy_dly);
      busy_cnt  = busy_cnt + 1;
      bus_rdata = bus_addr ^ 32'hA5A5_0000;
    end else begin
      bus_ready = 1'b0;
      busy_cnt  = 0;
      bus_rdata = '0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (if_done) begin
        if (if_q.size() == 0) chk("if_done_unexpected", {31'd0, if_done}, 32'd0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
        if_seen++;
      end
      if (mem_done) begin
        if (mem_q.size() == 0) chk("mem_done_unexpected", {31'd0, mem_done}, 32'd0);
        else chk("mem_rdata", mem_rdata, mem_q.pop_front());
        mem_seen++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_cnt(input bit is_if, input int target, input string nm);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (((is_if ? if_seen : mem_seen) < target) && n < 40);
    checks++;
    if ((is_if ? if_seen : mem_seen) < target) begin
      errors++;
      $display("FAIL %s timeout seen=%0d need=%0d", nm, (is_if ? if_seen : mem_seen), target);
    end
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    smp(); smp();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_stall", {26'd0, stall}, 32'd0);
    nxt(); rst = 1'b1; nxt();

    // 1: single fetch, immediate ready
    rdy_dly = 1; if_addr = 32'h300; if_req = 1'b1; if_q.push_back(32'hA5A5_0300);
    smp();
    chk("t1_stall_wait", {26'd0, stall}, 32'b000011);
    chk("t1_bus_idle", {31'd0, bus_req}, 32'd0);
    nxt(); smp();
    chk("t1_bus_req", {31'd0, bus_req}, 32'd1);
    chk("t1_bus_addr", bus_addr, 32'h300);
    chk("t1_bus_we", {31'd0, bus_we}, 32'd0);
    chk("t1_bus_sel", {28'd0, bus_sel}, 32'hF);
    chk("t1_stall_busy", {26'd0, stall}, 32'b000011);
    nxt(); smp();
    chk("t1_if_done_lat2", {31'd0, if_done}, 32'd1);
    chk("t1_stall_clr", {26'd0, stall}, 32'd0);
    chk("t1_bus_drop", {31'd0, bus_req}, 32'd0);
    wait_cnt(1'b1, 1, "t1_if_done");
    if_req = 1'b0;
    nxt();

    // 2: IF and MEM together; MEM first, 3-cycle bus
    rdy_dly = 3;
    if_addr = 32'h100; if_req = 1'b1;
    mem_addr = 32'h200; mem_we = 1'b0; mem_sel = 4'hF; mem_req = 1'b1;
    mem_q.push_back(32'hA5A5_0200); if_q.push_back(32'hA5A5_0100);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t2_stall_mem", {26'd0, stall}, 32'b011111);
      if (i == 1) begin
        chk("t2_bus_addr_mem", bus_addr, 32'h200);
        chk("t2_bus_we_load", {31'd0, bus_we}, 32'd0);
      end
      nxt();
    end
    smp();
    chk("t2_mem_done", {31'd0, mem_done}, 32'd1);
    chk("t2_stall_if", {26'd0, stall}, 32'b000011);
    chk("t2_idle_gap", {31'd0, bus_req}, 32'd0);
    mem_req = 1'b0;
    nxt(); smp();
    chk("t2_if_grant", {31'd0, bus_req}, 32'd1);
    chk("t2_bus_addr_if", bus_addr, 32'h100);
    wait_cnt(1'b1, 2, "t2_if_done");
    if_req = 1'b0;
    nxt();

    // 3: flush while IF busy; the refetch uses the new address
    rdy_dly = 4; if_addr = 32'h400; if_req = 1'b1; if_q.push_back(32'hA5A5_0440);
    smp(); nxt();
    if_flush = 1'b1; if_addr = 32'h440;
    smp();
    chk("t3_first_addr", bus_addr, 32'h400);
    nxt();
    if_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t3_no_done", {31'd0, if_done}, 32'd0);
      if (i == 3) chk("t3_gap", {31'd0, bus_req}, 32'd0);
      nxt();
    end
    smp();
    chk("t3_refetch_req", {31'd0, bus_req}, 32'd1);
    chk("t3_refetch_addr", bus_addr, 32'h440);
    wait_cnt(1'b1, 3, "t3_if_done");
    if_req = 1'b0;
    nxt();

    // 4: store, mem_req dropped mid-transfer; load data register holds
    rdy_dly = 2;
    mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h500; mem_wdata = 32'hDEAD_BEEF; mem_req = 1'b1;
    mem_q.push_back(32'hA5A5_0200);
    smp(); nxt(); smp();
    chk("t4_bus_we", {31'd0, bus_we}, 32'd1);
    chk("t4_bus_sel", {28'd0, bus_sel}, 32'b0011);
    chk("t4_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("t4_bus_addr", bus_addr, 32'h500);
    nxt();
    mem_req = 1'b0;
    smp();
    chk("t4_req_held", {31'd0, bus_req}, 32'd1);
    chk("t4_wdata_stable", bus_wdata, 32'hDEAD_BEEF);
    wait_cnt(1'b0, 2, "t4_mem_done");
    mem_we = 1'b0;
    nxt();

    // 5: load-use stall alone, then with MEM pending
    id_stall_req = 1'b1;
    smp();
    chk("t5_stall_id", {26'd0, stall}, 32'b000111);
    nxt();
    rdy_dly = 1; mem_addr = 32'h600; mem_sel = 4'hF; mem_req = 1'b1;
    mem_q.push_back(32'hA5A5_0600);
    smp();
    chk("t5_stall_id_mem", {26'd0, stall}, 32'b011111);
    wait_cnt(1'b0, 3, "t5_mem_done");
    mem_req = 1'b0; id_stall_req = 1'b0;
    smp();
    chk("t5_stall_none", {26'd0, stall}, 32'd0);
    nxt();

    // 6: reset while MEM busy
    rdy_dly = 100; mem_addr = 32'h700; mem_req = 1'b1;
    nxt(); smp();
    chk("t6_busy", {31'd0, bus_req}, 32'd1);
    nxt();
    rst = 1'b0;
    #1;
    chk("t6_async_drop", {31'd0, bus_req}, 32'd0);
    chk("t6_rst_mem_rdata", mem_rdata, 32'd0);
    mem_req = 1'b0;
    nxt(); nxt();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t6_no_done", {31'd0, mem_done}, 32'd0);
      chk("t6_no_req", {31'd0, bus_req}, 32'd0);
      nxt();
    end

    chk("end_if_q_empty", if_q.size(), 32'd0);
    chk("end_mem_q_empty", mem_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
